alu_writeback: RTL
==================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-002 The port clk SHALL be an input of width 1: the single clock.
REQ-003 The port reset SHALL be an input of width 1: asynchronous, active-low reset.
REQ-004 The port in_valid SHALL be an input of width 1: the execute stage presents an entry.
REQ-005 The port in_ready SHALL be an output of width 1: the block accepts the entry this cycle.
REQ-006 The port alu_result SHALL be an input of width 32: the ALU result.
REQ-007 The port alu_nzcv SHALL be an input of width 4: ALU flags {N,Z,C,V}.
REQ-008 The port result_writeback SHALL be an input of width 1: the result targets a register.
REQ-009 The port rd SHALL be an input of width 4: the destination register index.
REQ-010 The port set_flags SHALL be an input of width 1: the S-bit.
REQ-011 The port cond SHALL be an input of width 4: the ARM condition field.
REQ-012 The port rf_we SHALL be an output of width 1: register-file write request.
REQ-013 The port rf_waddr SHALL be an output of width 4: the write address.
REQ-014 The port rf_wdata SHALL be an output of width 32: the write data.
REQ-015 The port rf_ready SHALL be an input of width 1: the register file accepts the write.
REQ-016 The port cpsr_nzcv SHALL be an output of width 4: the committed CPSR flags, fed back to the ALU carry-in and to condition logic.
REQ-017 The port pc_flush SHALL be an output of width 1: a one-cycle pulse after a committed write to r15.
REQ-018 The port retired_cnt SHALL be an output of width CNT_W: the count of condition-passed commits.

Function
REQ-019 The block SHALL hold a single-entry holding register with states EMPTY and FULL.
REQ-020 The block SHALL accept an entry when in_valid and in_ready are both high, and the holding register SHALL go FULL on the next edge.
REQ-021 The condition pass flag SHALL be computed from the held cond against cpsr_nzcv using the ARM table (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL); 4'hF SHALL never pass.
REQ-022 rf_we SHALL equal FULL and pass and held result_writeback, combinationally; rf_waddr and rf_wdata SHALL come from the held entry.
REQ-023 A commit SHALL occur when FULL and (not rf_we, or rf_ready).
REQ-024 On commit, if pass and set_flags, cpsr_nzcv SHALL load the held nzcv at the edge; otherwise it SHALL hold.
REQ-025 On commit, if pass, retired_cnt SHALL increment by 1 and wrap to 0 after all-ones.
REQ-026 A failed condition SHALL commit in one cycle with no write, no flag update and no count.
REQ-027 in_ready SHALL equal not pc_flush and (EMPTY or commit), so a back-to-back entry is accepted in the same cycle as a commit, with zero bubbles.
REQ-028 The latency from accept to rf_we SHALL be 1 cycle, and the throughput SHALL be 1 entry per cycle while rf_ready is high.
REQ-029 While rf_ready is low and rf_we is high, the held entry and all outputs SHALL remain stable.
REQ-030 On a commit with rf_we, rf_ready and rd equal to 15, pc_flush SHALL be 1 in the next cycle only.
REQ-031 While pc_flush is high, in_valid SHALL be ignored, and the holding register SHALL be EMPTY.
REQ-032 A commit and a new accept in the same cycle SHALL update the CPSR from the old entry, and the new entry SHALL evaluate its condition against the updated flags in the following cycle.

Reset
REQ-033 On reset low, the holding register SHALL be EMPTY, and cpsr_nzcv, retired_cnt and pc_flush SHALL be 0 immediately, without waiting for a clock edge.
REQ-034 Reset asserted mid-stall SHALL discard the held entry, and rf_we SHALL drop to 0 without waiting for a clock edge.
REQ-035 After reset deasserts, in_ready SHALL be 1 at the first clock edge.

Structure
REQ-036 The condition-code encodings (EQ..NV) and the NZCV bit positions SHALL live in a shared package, alongside the ALU opcode defines.
REQ-037 The condition evaluator SHALL be a combinational sub-module named cond_check, with inputs cond and nzcv and output pass, reusable by the fetch and decode stages.
REQ-038 There SHALL be no other sub-modules.

Verification
REQ-039 The bench SHALL cover: reset, then accept {result 0x12345678, rd 3, wb 1, S 1, nzcv 4'b0010, cond AL} with rf_ready 1 -> next cycle rf_we 1, waddr 3, wdata 0x12345678; the following cycle cpsr_nzcv is 4'b0010 and retired_cnt is 1.
REQ-040 The bench SHALL cover: with cpsr Z=0, an entry with cond EQ -> rf_we stays 0, cpsr is unchanged, retired_cnt is unchanged, and in_ready stays 1.
REQ-041 The bench SHALL cover: rf_ready held 0 for 3 cycles with in_valid high -> in_ready 0 and outputs stable for 3 cycles; then rf_ready 1 -> commit, and the next entry is accepted in the same cycle.
REQ-042 The bench SHALL cover: a back-to-back CMP (S 1, wb 0, nzcv 4'b0100) followed by MOV with cond EQ -> MOV writes, since it uses the updated flag Z=1.
REQ-043 The bench SHALL cover: a write to rd 15 that commits -> pc_flush is 1 for exactly one cycle, with in_ready 0 in that cycle, and an in_valid presented during that cycle is dropped.
REQ-044 The bench SHALL cover: retired_cnt preloaded near wrap (CNT_W 4, 15 commits) -> the next passing commit yields retired_cnt 0.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared ALU/writeback definitions: condition codes, flag bits,
// opcodes and the execute-to-writeback entry bundle.
package alu_writeback_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  nzcv;
    logic        wb;
    logic [3:0]  rd;
    logic        s;
    logic [3:0]  cond;
  } wb_entry_t;

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluator; purely combinational so fetch and
// decode can reuse it against their own flag views.
module cond_check
  import alu_writeback_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: single-entry holding register, conditional
// commit to the register file, CPSR flags and retire counter.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_nzcv,
  input  logic             result_writeback,
  input  logic [3:0]       rd,
  input  logic             set_flags,
  input  logic [3:0]       cond,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  input  logic             rf_ready,
  output logic [3:0]       cpsr_nzcv,
  output logic             pc_flush,
  output logic [CNT_W-1:0] retired_cnt
);

  wb_state_e state_q, state_d;
  wb_entry_t held_q;
  logic      full;
  logic      pass;
  logic      commit;
  logic      accept;
  logic      flush_d;

  cond_check u_cond (
    .cond (held_q.cond),
    .nzcv (cpsr_nzcv),
    .pass (pass)
  );

  assign full     = (state_q == WB_FULL);
  assign rf_we    = full & pass & held_q.wb;
  assign rf_waddr = held_q.rd;
  assign rf_wdata = held_q.result;
  assign commit   = full & (~rf_we | rf_ready);
  assign in_ready = ~pc_flush & (~full | commit);
  assign accept   = in_valid & in_ready;
  assign flush_d  = commit & rf_we & (held_q.rd == PC_REG);

  // A younger entry taken alongside a PC write is wrong-path: squash it.
  always_comb begin
    state_d = state_q;
    if (flush_d) begin
      state_d = WB_EMPTY;
    end else if (accept) begin
      state_d = WB_FULL;
    end else if (commit) begin
      state_d = WB_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_q <= '0;
    end else if (accept) begin
      held_q <= '{
        result: alu_result,
        nzcv:   alu_nzcv,
        wb:     result_writeback,
        rd:     rd,
        s:      set_flags,
        cond:   cond
      };
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpsr_nzcv   <= '0;
      retired_cnt <= '0;
      pc_flush    <= 1'b0;
    end else begin
      pc_flush <= flush_d;
      if (commit && pass) begin
        retired_cnt <= retired_cnt + 1'b1;
        if (held_q.s) begin
          cpsr_nzcv <= held_q.nzcv;
        end
      end
    end
  end

endmodule
